// File: rtl/alu_multi_byte.sv
// alu_multi_byte: multi-cycle accumulator ALU that walks BYTES 8-bit slices,
// LSB first, chaining carry/borrow and producing {Z,N,H,C} flags at the end.
module alu_multi_byte #(
    parameter int unsigned BYTES = 2
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_n,
    input  logic                 i_Enable,
    input  logic                 i_Start,
    input  logic [2:0]           i_Op,
    input  logic [8*BYTES-1:0]   i_A,
    input  logic [8*BYTES-1:0]   i_B,
    input  logic                 i_Flags_Load,
    input  logic [3:0]           i_Flags_Data,
    output logic                 o_Busy,
    output logic                 o_Done,
    output logic [8*BYTES-1:0]   o_Result,
    output logic [3:0]           o_Flags
);

    localparam int unsigned WIDTH  = 8 * BYTES;
    localparam int unsigned CNT_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned BASE_W = CNT_W + 3;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_ADC = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_SBC = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_CP  = 3'd7;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_n;
    logic               accept_c;
    logic               last_c;

    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   shadow_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               carry_q;
    logic [7:0]         zacc_q;

    logic               flag_c_c;
    logic               cin_c;
    logic [BASE_W-1:0]  base_c;
    logic [7:0]         a_byte_c;
    logic [7:0]         b_byte_c;
    logic [8:0]         sum9_c;
    logic [8:0]         dif9_c;
    logic [4:0]         sum5_c;
    logic [4:0]         dif5_c;
    logic [7:0]         r_byte_c;
    logic               cout_c;
    logic               half_c;
    logic               is_sub_c;
    logic               zero_c;
    logic [WIDTH-1:0]   shadow_n_c;

    // Carry-in chosen at accept: a same-cycle flag load supplies C directly.
    always_comb begin
        flag_c_c = i_Flags_Load ? i_Flags_Data[0] : o_Flags[0];
        cin_c    = ((i_Op == OP_ADC) || (i_Op == OP_SBC)) ? flag_c_c : 1'b0;
    end

    // Current byte slice: add/subtract/logic with chained carry.
    always_comb begin
        base_c     = {cnt_q, 3'b000};
        a_byte_c   = 8'(a_q >> base_c);
        b_byte_c   = 8'(b_q >> base_c);
        sum9_c     = {1'b0, a_byte_c} + {1'b0, b_byte_c} + 9'(carry_q);
        dif9_c     = {1'b0, a_byte_c} - {1'b0, b_byte_c} - 9'(carry_q);
        sum5_c     = {1'b0, a_byte_c[3:0]} + {1'b0, b_byte_c[3:0]} + 5'(carry_q);
        dif5_c     = {1'b0, a_byte_c[3:0]} - {1'b0, b_byte_c[3:0]} - 5'(carry_q);
        r_byte_c   = 8'h00;
        cout_c     = 1'b0;
        half_c     = 1'b0;
        is_sub_c   = 1'b0;
        case (op_q)
            OP_ADD, OP_ADC: begin
                r_byte_c = sum9_c[7:0];
                cout_c   = sum9_c[8];
                half_c   = sum5_c[4];
            end
            OP_SUB, OP_SBC, OP_CP: begin
                r_byte_c = dif9_c[7:0];
                cout_c   = dif9_c[8];
                half_c   = dif5_c[4];
                is_sub_c = 1'b1;
            end
            OP_AND: begin
                r_byte_c = a_byte_c & b_byte_c;
                half_c   = 1'b1;
            end
            OP_XOR:  r_byte_c = a_byte_c ^ b_byte_c;
            OP_OR:   r_byte_c = a_byte_c | b_byte_c;
            default: r_byte_c = 8'h00;
        endcase
        zero_c     = ~|(zacc_q | r_byte_c);
        shadow_n_c = (shadow_q & ~(WIDTH'(8'hFF) << base_c)) | (WIDTH'(r_byte_c) << base_c);
    end

    // State register.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        state_n  = state_q;
        accept_c = 1'b0;
        last_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_Enable && i_Start) begin
                    accept_c = 1'b1;
                    state_n  = RUN;
                end
            end
            RUN: begin
                if (i_Enable && (cnt_q == LAST_BYTE)) begin
                    last_c  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Operand latch, byte iteration, commit and flag register.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            op_q     <= 3'd0;
            a_q      <= '0;
            b_q      <= '0;
            shadow_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            zacc_q   <= 8'h00;
            o_Busy   <= 1'b0;
            o_Done   <= 1'b0;
            o_Result <= '0;
            o_Flags  <= 4'h0;
        end else if (i_Enable) begin
            if (state_q == IDLE) begin
                o_Done <= 1'b0;
                if (i_Flags_Load) begin
                    o_Flags <= i_Flags_Data;
                end
                if (accept_c) begin
                    op_q    <= i_Op;
                    a_q     <= i_A;
                    b_q     <= i_B;
                    carry_q <= cin_c;
                    zacc_q  <= 8'h00;
                    cnt_q   <= '0;
                    o_Busy  <= 1'b1;
                end
            end else begin
                shadow_q <= shadow_n_c;
                zacc_q   <= zacc_q | r_byte_c;
                carry_q  <= cout_c;
                cnt_q    <= cnt_q + 1'b1;
                if (last_c) begin
                    if (op_q != OP_CP) begin
                        o_Result <= shadow_n_c;
                    end
                    o_Flags <= {zero_c, is_sub_c, half_c, cout_c};
                    o_Busy  <= 1'b0;
                    o_Done  <= 1'b1;
                    cnt_q   <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_multi_byte.sv
// Testbench for alu_multi_byte (BYTES=2): directed steps with a result/flag
// scoreboard fed by a full-width reference model.
module tb_alu_multi_byte;

    localparam int unsigned BYTES = 2;
    localparam int unsigned WIDTH = 8 * BYTES;

    logic             i_Clk = 1'b0;
    logic             i_Rst_n = 1'b0;
    logic             i_Enable = 1'b0;
    logic             i_Start = 1'b0;
    logic [2:0]       i_Op = 3'd0;
    logic [WIDTH-1:0] i_A = '0;
    logic [WIDTH-1:0] i_B = '0;
    logic             i_Flags_Load = 1'b0;
    logic [3:0]       i_Flags_Data = 4'h0;
    logic             o_Busy;
    logic             o_Done;
    logic [WIDTH-1:0] o_Result;
    logic [3:0]       o_Flags;

    alu_multi_byte #(.BYTES(BYTES)) dut (
        .i_Clk        (i_Clk),
        .i_Rst_n      (i_Rst_n),
        .i_Enable     (i_Enable),
        .i_Start      (i_Start),
        .i_Op         (i_Op),
        .i_A          (i_A),
        .i_B          (i_B),
        .i_Flags_Load (i_Flags_Load),
        .i_Flags_Data (i_Flags_Data),
        .o_Busy       (o_Busy),
        .o_Done       (o_Done),
        .o_Result     (o_Result),
        .o_Flags      (o_Flags)
    );

    always #5 i_Clk = ~i_Clk;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic [3:0]       flg;
    } exp_t;

    exp_t             sb[$];
    logic [WIDTH-1:0] m_res = '0;
    logic [3:0]       m_flg = 4'h0;
    int               checks = 0;
    int               fails = 0;

    // Reference: whole-width arithmetic, H from the carry into bit WIDTH-4.
    function automatic exp_t model(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b, input logic c_flag,
                                   input logic [WIDTH-1:0] prev);
        logic             cin;
        logic [WIDTH:0]   full;
        logic [WIDTH-4:0] low;
        logic [WIDTH-1:0] r;
        logic             h;
        logic             c;
        logic             n;
        exp_t             e;
        cin  = ((op == 3'd1) || (op == 3'd3)) ? c_flag : 1'b0;
        n    = (op == 3'd2) || (op == 3'd3) || (op == 3'd7);
        full = '0;
        low  = '0;
        r    = '0;
        h    = 1'b0;
        c    = 1'b0;
        case (op)
            3'd0, 3'd1: begin
                full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
                r    = full[WIDTH-1:0];
                c    = full[WIDTH];
                low  = {1'b0, a[WIDTH-5:0]} + {1'b0, b[WIDTH-5:0]} + {{(WIDTH-4){1'b0}}, cin};
                h    = low[WIDTH-4];
            end
            3'd2, 3'd3, 3'd7: begin
                r = a - b - {{(WIDTH-1){1'b0}}, cin};
                c = ({1'b0, a} < ({1'b0, b} + {{WIDTH{1'b0}}, cin}));
                h = ({1'b0, a[WIDTH-5:0]} < ({1'b0, b[WIDTH-5:0]} + {{(WIDTH-4){1'b0}}, cin}));
            end
            3'd4: begin r = a & b; h = 1'b1; end
            3'd5: r = a ^ b;
            default: r = a | b;
        endcase
        e.res = (op == 3'd7) ? prev : r;
        e.flg = {(r == '0), n, h, c};
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    // Drive an accept edge and push the model's expected completion.
    task automatic start_op(input string tag, input logic [2:0] op, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] b, input logic ld, input logic [3:0] ld_data);
        exp_t e;
        i_Enable     = 1'b1;
        i_Op         = op;
        i_A          = a;
        i_B          = b;
        i_Flags_Load = ld;
        i_Flags_Data = ld_data;
        i_Start      = 1'b1;
        if (ld) m_flg = ld_data;
        e     = model(op, a, b, m_flg[0], m_res);
        m_res = e.res;
        m_flg = e.flg;
        sb.push_back(e);
        tick();
        i_Start      = 1'b0;
        i_Flags_Load = 1'b0;
        chk({tag, " busy after accept"}, 32'(o_Busy), 32'd1);
        chk({tag, " done after accept"}, 32'(o_Done), 32'd0);
    endtask

    // Wait (bounded) for o_Done, check latency, then pop and compare.
    task automatic wait_done(input string tag, input int cycles);
        int   n;
        exp_t e;
        n = 0;
        while (n <= 20) begin
            tick();
            n++;
            if (o_Done === 1'b1) break;
        end
        chk({tag, " latency"}, 32'(n), 32'(cycles));
        chk({tag, " busy at done"}, 32'(o_Busy), 32'd0);
        chk({tag, " scoreboard depth"}, 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, " result"}, 32'(o_Result), 32'(e.res));
            chk({tag, " flags"}, 32'(o_Flags), 32'(e.flg));
        end
    endtask

    initial begin
        exp_t e;

        // Reset state
        i_Rst_n = 1'b0;
        tick();
        tick();
        chk("reset busy", 32'(o_Busy), 32'd0);
        chk("reset done", 32'(o_Done), 32'd0);
        chk("reset result", 32'(o_Result), 32'd0);
        chk("reset flags", 32'(o_Flags), 32'd0);
        i_Rst_n  = 1'b1;
        i_Enable = 1'b1;
        tick();

        // ADD with nibble carry into MS byte
        start_op("add", 3'd0, 16'h0FFF, 16'h0001, 1'b0, 4'h0);
        wait_done("add", BYTES);
        chk("add literal result", 32'(o_Result), 32'h1000);
        chk("add literal flags", 32'(o_Flags), 32'h2);
        tick();
        chk("add done pulse clears", 32'(o_Done), 32'd0);

        // Direct flag load, then SBC/ADC chained through C
        i_Flags_Load = 1'b1;
        i_Flags_Data = 4'h1;
        tick();
        i_Flags_Load = 1'b0;
        m_flg = 4'h1;
        chk("flag load", 32'(o_Flags), 32'h1);
        start_op("sbc", 3'd3, 16'h0000, 16'h0000, 1'b0, 4'h0);
        wait_done("sbc", BYTES);
        start_op("adc", 3'd1, 16'hFFFF, 16'h0000, 1'b0, 4'h0);
        wait_done("adc", BYTES);

        // CP leaves result untouched; AND sets H
        start_op("add aaaa", 3'd0, 16'hAAAA, 16'h0000, 1'b0, 4'h0);
        wait_done("add aaaa", BYTES);
        start_op("cp", 3'd7, 16'h1234, 16'h1234, 1'b0, 4'h0);
        wait_done("cp", BYTES);
        chk("cp literal result", 32'(o_Result), 32'hAAAA);
        start_op("and", 3'd4, 16'hF0F0, 16'h0FF0, 1'b0, 4'h0);
        wait_done("and", BYTES);

        // Enable gaps between bytes and while o_Done is high
        start_op("gap", 3'd0, 16'h00FF, 16'h0101, 1'b0, 4'h0);
        tick();
        i_Enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("gap busy held", 32'(o_Busy), 32'd1);
            chk("gap done low", 32'(o_Done), 32'd0);
        end
        i_Enable = 1'b1;
        tick();
        chk("gap done", 32'(o_Done), 32'd1);
        e = sb.pop_front();
        chk("gap result", 32'(o_Result), 32'(e.res));
        chk("gap flags", 32'(o_Flags), 32'(e.flg));
        i_Enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("gap done held", 32'(o_Done), 32'd1);
        end
        i_Enable = 1'b1;
        tick();
        chk("gap done clears", 32'(o_Done), 32'd0);

        // Start and flag load during RUN are ignored
        start_op("sub", 3'd2, 16'h0100, 16'h0001, 1'b0, 4'h0);
        i_Start      = 1'b1;
        i_Op         = 3'd0;
        i_A          = 16'hFFFF;
        i_B          = 16'hFFFF;
        i_Flags_Load = 1'b1;
        i_Flags_Data = 4'hF;
        tick();
        i_Start      = 1'b0;
        i_Flags_Load = 1'b0;
        wait_done("sub", BYTES - 1);
        tick();
        chk("sub no queued start", 32'(o_Busy), 32'd0);

        // Reset mid-RUN with enable low
        start_op("abort", 3'd0, 16'h1111, 16'h2222, 1'b0, 4'h0);
        i_Enable = 1'b0;
        i_Rst_n  = 1'b0;
        tick();
        chk("abort busy", 32'(o_Busy), 32'd0);
        chk("abort done", 32'(o_Done), 32'd0);
        chk("abort result", 32'(o_Result), 32'd0);
        chk("abort flags", 32'(o_Flags), 32'd0);
        i_Rst_n = 1'b1;
        sb.delete();
        m_res = '0;
        m_flg = 4'h0;
        start_op("post reset adc", 3'd1, 16'h1234, 16'h0001, 1'b0, 4'h0);
        wait_done("post reset adc", BYTES);

        // Back-to-back random ops, each accepted on the edge clearing o_Done
        for (int i = 0; i < 8; i++) begin
            start_op("rand", 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                     1'b0, 4'h0);
            wait_done("rand", BYTES);
        end
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
